// File: rtl/arf_multiport_if.sv
// ---------------------------------------------------------------------------
// arf_multiport_if
// Bundle between the ROB commit stage / readout path (master) and the
// architectural register file (slave).
//   wr_en      [NUM_WR]          per-port retire strobe
//   wr_addr    [NUM_WR*AR_SIZE]  packed write addresses, port k at k*AR_SIZE
//   wr_data    [NUM_WR*DATA_W]   packed write data
//   rd_en      [NUM_RD]          per-port read request
//   rd_addr    [NUM_RD*AR_SIZE]  packed read addresses
//   rd_data    [NUM_RD*DATA_W]   packed registered read data
//   rd_valid   [NUM_RD]          rd_data for port j valid this cycle
//   clr_req                      request full-file clear (RUN only)
//   ready                        file is in RUN
//   commit_cnt [32]              accepted retire writes since reset
// ---------------------------------------------------------------------------
interface arf_multiport_if #(
  parameter int AR_SIZE = 6,
  parameter int DATA_W  = 32,
  parameter int NUM_RD  = 2,
  parameter int NUM_WR  = 2
);
  logic [NUM_WR-1:0]         wr_en;
  logic [NUM_WR*AR_SIZE-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0]  wr_data;
  logic [NUM_RD-1:0]         rd_en;
  logic [NUM_RD*AR_SIZE-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0]  rd_data;
  logic [NUM_RD-1:0]         rd_valid;
  logic                      clr_req;
  logic                      ready;
  logic [31:0]               commit_cnt;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, clr_req,
    input  rd_data, rd_valid, ready, commit_cnt
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, clr_req,
    output rd_data, rd_valid, ready, commit_cnt
  );
endinterface

// File: rtl/arf_multiport.sv
// ---------------------------------------------------------------------------
// arf_multiport
// Architectural register file: NUM_WR retire write ports, NUM_RD registered
// read ports, sequential clear engine (after reset and on clr_req), highest
// port index wins on same-address writes, retirement counter.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - arf_multiport_if.slave (write/read/clear/status signals)
// Optional feature macro: ARF_BYPASS_EN
//   defined   -> write-first reads (same-cycle write data forwarded)
//   undefined -> read-first reads (array value before the edge)
// ---------------------------------------------------------------------------
module arf_multiport #(
  parameter int AR_SIZE  = 6,
  parameter int AR_ARRAY = 64,
  parameter int DATA_W   = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2
) (
  input  logic            clk,
  input  logic            rst,
  arf_multiport_if.slave  bus
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  localparam logic [AR_SIZE-1:0] LAST_IDX  = AR_SIZE'(AR_ARRAY - 1);
  localparam logic [AR_SIZE:0]   ARRAY_LIM = (AR_SIZE + 1)'(AR_ARRAY);

  // Entry 0 is hardwired zero and addresses past the array are discarded.
  function automatic logic addr_ok(input logic [AR_SIZE-1:0] a);
    return (a != '0) && ({1'b0, a} < ARRAY_LIM);
  endfunction

  logic [DATA_W-1:0] mem [AR_ARRAY];

  logic [0:0]               state_q, state_d;
  logic [AR_SIZE-1:0]       clr_ptr_q, clr_ptr_d;
  logic [31:0]              commit_cnt_q, commit_cnt_d;
  logic [NUM_RD-1:0]        rd_valid_q, rd_valid_d;
  logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
  logic [31:0]              wr_pop;
  logic                     run;

  logic [AR_SIZE-1:0] wr_addr_w [NUM_WR];
  logic [DATA_W-1:0]  wr_data_w [NUM_WR];

  assign run = (state_q == ST_RUN);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WR; gi++) begin : g_wr
      assign wr_addr_w[gi] = bus.wr_addr[gi*AR_SIZE +: AR_SIZE];
      assign wr_data_w[gi] = bus.wr_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Sweep FSM: CLEAR walks every entry once, then RUN until clr_req.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (run) begin
      if (bus.clr_req) begin
        state_d   = ST_CLEAR;
        clr_ptr_d = '0;
      end
    end else begin
      clr_ptr_d = clr_ptr_q + 1'b1;
      if (clr_ptr_q == LAST_IDX) begin
        state_d = ST_RUN;
      end
    end
  end

  // Every strobe counts, including ones whose address is discarded.
  always_comb begin
    wr_pop = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      wr_pop = wr_pop + 32'(bus.wr_en[k]);
    end
    commit_cnt_d = run ? (commit_cnt_q + wr_pop) : commit_cnt_q;
  end

  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [AR_SIZE-1:0] ra;
      logic [DATA_W-1:0]  rv;

      assign ra = bus.rd_addr[gi*AR_SIZE +: AR_SIZE];

      always_comb begin
        rv = '0;
        if (addr_ok(ra)) begin
          rv = mem[ra];
`ifdef ARF_BYPASS_EN
          // Ascending scan so the highest matching port is forwarded last.
          for (int k = 0; k < NUM_WR; k++) begin
            if (bus.wr_en[k] && (wr_addr_w[k] == ra)) begin
              rv = wr_data_w[k];
            end
          end
`endif
        end
      end

      assign rd_valid_d[gi] = run & bus.rd_en[gi];
      // Data holds when the port is not read in RUN.
      assign rd_data_d[gi*DATA_W +: DATA_W] =
        rd_valid_d[gi] ? rv : rd_data_q[gi*DATA_W +: DATA_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_CLEAR;
      clr_ptr_q    <= '0;
      commit_cnt_q <= '0;
      rd_valid_q   <= '0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      clr_ptr_q    <= clr_ptr_d;
      commit_cnt_q <= commit_cnt_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Array is not reset; the sweep zeroes it. Ports are applied in ascending
  // order so the last (highest-index) assignment to an address wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!run) begin
        mem[clr_ptr_q] <= '0;
      end else begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (bus.wr_en[k] && addr_ok(wr_addr_w[k])) begin
            mem[wr_addr_w[k]] <= wr_data_w[k];
          end
        end
      end
    end
  end

  assign bus.ready      = run;
  assign bus.commit_cnt = commit_cnt_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_data_q;

endmodule

// File: tb/tb_arf_multiport.sv
module tb_arf_multiport;
  localparam int AR_SIZE  = 6;
  localparam int AR_ARRAY = 64;
  localparam int DATA_W   = 32;
  localparam int NUM_RD   = 2;
  localparam int NUM_WR   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arf_multiport_if #(.AR_SIZE(AR_SIZE), .DATA_W(DATA_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) bus ();

  arf_multiport #(
    .AR_SIZE(AR_SIZE), .AR_ARRAY(AR_ARRAY), .DATA_W(DATA_W),
    .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: register contents, cycles of sweep left, counter, read outputs.
  logic [DATA_W-1:0] m_mem [AR_ARRAY];
  int                clr_left;
  logic [31:0]       m_cnt;
  logic [DATA_W-1:0] m_rd  [NUM_RD];
  logic              m_vld [NUM_RD];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] ref_read(input int addr);
    logic [DATA_W-1:0] v;
    if (addr == 0 || addr >= AR_ARRAY) return '0;
    v = m_mem[addr];
`ifdef ARF_BYPASS_EN
    for (int k = 0; k < NUM_WR; k++)
      if (bus.wr_en[k] && int'(bus.wr_addr[k*AR_SIZE +: AR_SIZE]) == addr)
        v = bus.wr_data[k*DATA_W +: DATA_W];
`endif
    return v;
  endfunction

  // Apply the rules for the upcoming edge, using the inputs currently driven.
  task automatic model_edge();
    if (rst) begin
      clr_left = AR_ARRAY;
      m_cnt = 0;
      for (int j = 0; j < NUM_RD; j++) begin m_rd[j] = '0; m_vld[j] = 1'b0; end
    end else if (clr_left > 0) begin
      m_mem[AR_ARRAY - clr_left] = '0;
      clr_left--;
      for (int j = 0; j < NUM_RD; j++) m_vld[j] = 1'b0;
    end else begin
      for (int j = 0; j < NUM_RD; j++) begin
        m_vld[j] = bus.rd_en[j];
        if (bus.rd_en[j]) m_rd[j] = ref_read(int'(bus.rd_addr[j*AR_SIZE +: AR_SIZE]));
      end
      for (int k = 0; k < NUM_WR; k++) begin
        int a;
        a = int'(bus.wr_addr[k*AR_SIZE +: AR_SIZE]);
        if (bus.wr_en[k]) begin
          m_cnt = m_cnt + 1;
          if (a != 0 && a < AR_ARRAY) m_mem[a] = bus.wr_data[k*DATA_W +: DATA_W];
        end
      end
      if (bus.clr_req) clr_left = AR_ARRAY;
    end
  endtask

  task automatic compare_all();
    check("ready", bus.ready, (clr_left == 0));
    check("commit_cnt", bus.commit_cnt, m_cnt);
    for (int j = 0; j < NUM_RD; j++) begin
      check($sformatf("rd_valid%0d", j), bus.rd_valid[j], m_vld[j]);
      check($sformatf("rd_data%0d", j), bus.rd_data[j*DATA_W +: DATA_W], m_rd[j]);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    bus.wr_en = '0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_en = '0; bus.rd_addr = '0; bus.clr_req = 1'b0;
  endtask

  task automatic set_wr(input int k, input logic en, input int addr, input logic [DATA_W-1:0] d);
    bus.wr_en[k] = en;
    bus.wr_addr[k*AR_SIZE +: AR_SIZE] = AR_SIZE'(addr);
    bus.wr_data[k*DATA_W +: DATA_W] = d;
  endtask

  task automatic set_rd(input int j, input logic en, input int addr);
    bus.rd_en[j] = en;
    bus.rd_addr[j*AR_SIZE +: AR_SIZE] = AR_SIZE'(addr);
  endtask

  task automatic rand_wr();
    for (int k = 0; k < NUM_WR; k++)
      set_wr(k, 1'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(0, AR_ARRAY-1)
                                                          : $urandom_range(0, 7), $urandom);
  endtask

  // Count cycles (the reset/clear edge being cycle 1) until ready rises.
  task automatic wait_ready(input string tag, input logic hold_wr);
    int n;
    n = 1;
    while (!bus.ready && n < 200) begin
      if (hold_wr) rand_wr();
      for (int j = 0; j < NUM_RD; j++) set_rd(j, 1'b1, $urandom_range(1, 7));
      tick();
      n++;
    end
    idle();
    check(tag, n, 65);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk);

    // 1: one-cycle reset, sweep with writes/reads attempted, then all reads 0
    tick();
    rst = 1'b0;
    wait_ready("t1_ready_cycle", 1'b1);
    for (int r = 0; r < AR_ARRAY; r += 2) begin
      set_rd(0, 1'b1, r); set_rd(1, 1'b1, r + 1);
      tick();
      check("t1_zero", bus.rd_data, '0);
    end
    idle();

    // 2: write r5 then read it
    set_wr(0, 1'b1, 5, 32'h11); tick(); idle();
    set_rd(0, 1'b1, 5); tick(); idle();
    check("t2_valid", bus.rd_valid[0], 1'b1);
    check("t2_data", bus.rd_data[DATA_W-1:0], 32'h11);
    check("t2_cnt", bus.commit_cnt, 32'd1);

    // 3: same address on both ports, higher port wins
    set_wr(0, 1'b1, 7, 32'hA); set_wr(1, 1'b1, 7, 32'hB); tick(); idle();
    set_rd(1, 1'b1, 7); tick(); idle();
    check("t3_data", bus.rd_data[DATA_W +: DATA_W], 32'hB);
    check("t3_cnt", bus.commit_cnt, 32'd3);

    // 4: write to r0 discarded but counted
    set_wr(1, 1'b1, 0, 32'hFFFF); tick(); idle();
    set_rd(0, 1'b1, 0); tick(); idle();
    check("t4_data", bus.rd_data[DATA_W-1:0], 32'h0);
    check("t4_cnt", bus.commit_cnt, 32'd4);

    // 5: read and write same address same cycle
    set_wr(0, 1'b1, 9, 32'h1); tick(); idle();
    set_wr(1, 1'b1, 9, 32'h3); set_rd(0, 1'b1, 9); tick(); idle();
`ifdef ARF_BYPASS_EN
    check("t5_data", bus.rd_data[DATA_W-1:0], 32'h3);
`else
    check("t5_data", bus.rd_data[DATA_W-1:0], 32'h1);
`endif

    // 6: clr_req with writes held, reset at sweep cycle 30
    bus.clr_req = 1'b1; rand_wr(); tick(); bus.clr_req = 1'b0;
    for (int i = 1; i < 30; i++) begin rand_wr(); tick(); end
    idle();
    rst = 1'b1; tick(); rst = 1'b0;
    wait_ready("t6_ready_cycle", 1'b1);
    for (int r = 0; r < AR_ARRAY; r += 2) begin
      set_rd(0, 1'b1, r); set_rd(1, 1'b1, r + 1);
      tick();
      check("t6_zero", bus.rd_data, '0);
    end
    idle();

    // Random traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      bus.clr_req = ($urandom_range(0, 149) == 0);
      rand_wr();
      for (int j = 0; j < NUM_RD; j++)
        set_rd(j, 1'($urandom), ($urandom_range(0, 2) == 0) ? $urandom_range(0, AR_ARRAY-1)
                                                            : $urandom_range(0, 7));
      tick();
    end
    rst = 1'b0;
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
